// File: rtl/wb_commit_arbiter_pkg.sv
// Shared widths and entry-layout helper for the writeback/commit arbiter.
// Entry layout, MSB first: {wr_reg, wr_csr, wregno, wcsrno, regval}.
package wb_commit_arbiter_pkg;

  localparam int DEF_DBITS     = 32;
  localparam int DEF_REGNOBITS = 5;
  localparam int DEF_CSRNOBITS = 12;

  function automatic int entry_bits(input int regno_bits, input int csrno_bits,
                                    input int data_bits);
    return 2 + regno_bits + csrno_bits + data_bits;
  endfunction

endpackage

// File: rtl/wb_commit_arbiter_chan_fifo.sv
// One producer channel: DEPTH-entry FIFO with full/empty from a registered
// occupancy count and a per-entry valid vector used by the pending-write query.
module wb_commit_arbiter_chan_fifo
  import wb_commit_arbiter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REGNOBITS = DEF_REGNOBITS,
  parameter int EBITS     = entry_bits(DEF_REGNOBITS, DEF_CSRNOBITS, DEF_DBITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [EBITS-1:0]     push_data,
  input  logic                 pop,
  output logic [EBITS-1:0]     head,
  output logic                 full,
  output logic                 empty,
  input  logic [REGNOBITS-1:0] query_regno,
  output logic                 query_hit
);

  localparam int PW = $clog2(DEPTH);

  logic [EBITS-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage needs no reset; vld alone says which slots hold live entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i][EBITS-1] && (query_regno != '0) &&
          (mem[i][EBITS-3 -: REGNOBITS] == query_regno)) begin
        query_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback/commit unit: per-channel FIFOs, round-robin grant onto the single
// register-file/CSR write port, retire counter and pending-write query for DE.
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DEPTH     = 4,
  parameter int DBITS     = DEF_DBITS,
  parameter int REGNOBITS = DEF_REGNOBITS,
  parameter int CSRNOBITS = DEF_CSRNOBITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           ch_valid,
  output logic [NCH-1:0]           ch_ready,
  input  logic [NCH-1:0]           ch_wr_reg,
  input  logic [NCH*REGNOBITS-1:0] ch_wregno,
  input  logic [NCH-1:0]           ch_wr_csr,
  input  logic [NCH*CSRNOBITS-1:0] ch_wcsrno,
  input  logic [NCH*DBITS-1:0]     ch_regval,
  input  logic [REGNOBITS-1:0]     query_regno,
  output logic                     query_hit,
  output logic                     wr_reg_WB,
  output logic [REGNOBITS-1:0]     wregno_WB,
  output logic                     wr_csr_WB,
  output logic [CSRNOBITS-1:0]     wcsrno_WB,
  output logic [DBITS-1:0]         regval_WB,
  output logic [DBITS-1:0]         retire_count
);

  localparam int EBITS = entry_bits(REGNOBITS, CSRNOBITS, DBITS);
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   empty;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   fifo_hit;
  logic [EBITS-1:0] head [NCH];
  logic [EBITS-1:0] grant_entry;
  logic [IW-1:0]    rr_last;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic             grant_valid;

  // Ready comes only from registered occupancy, so a full FIFO stays closed even while it pops.
  assign ch_ready = ~full;
  assign push     = ch_valid & ~full;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    wb_commit_arbiter_chan_fifo #(
      .DEPTH     (DEPTH),
      .REGNOBITS (REGNOBITS),
      .EBITS     (EBITS)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push[i]),
      .push_data   ({ch_wr_reg[i], ch_wr_csr[i],
                     ch_wregno[i*REGNOBITS +: REGNOBITS],
                     ch_wcsrno[i*CSRNOBITS +: CSRNOBITS],
                     ch_regval[i*DBITS +: DBITS]}),
      .pop         (pop[i]),
      .head        (head[i]),
      .full        (full[i]),
      .empty       (empty[i]),
      .query_regno (query_regno),
      .query_hit   (fifo_hit[i])
    );
  end

  // Scan rr_last+1, rr_last+2, ... so the last winner has lowest priority next time.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_last;
    cand        = rr_last;
    for (int k = 1; k <= NCH; k++) begin
      cand = IW'((int'(rr_last) + k) % NCH);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
  end

  assign grant_entry = head[grant_idx];

  // x0 writes still retire but never raise the GPR strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last      <= IW'(NCH - 1);
      wr_reg_WB    <= 1'b0;
      wr_csr_WB    <= 1'b0;
      wregno_WB    <= '0;
      wcsrno_WB    <= '0;
      regval_WB    <= '0;
      retire_count <= '0;
    end else if (grant_valid) begin
      rr_last      <= grant_idx;
      wr_reg_WB    <= grant_entry[EBITS-1] && (grant_entry[EBITS-3 -: REGNOBITS] != '0);
      wr_csr_WB    <= grant_entry[EBITS-2];
      wregno_WB    <= grant_entry[EBITS-3 -: REGNOBITS];
      wcsrno_WB    <= grant_entry[DBITS +: CSRNOBITS];
      regval_WB    <= grant_entry[DBITS-1:0];
      retire_count <= retire_count + DBITS'(1);
    end else begin
      wr_reg_WB <= 1'b0;
      wr_csr_WB <= 1'b0;
    end
  end

  assign query_hit = (|fifo_hit) ||
                     (wr_reg_WB && (query_regno != '0) && (wregno_WB == query_regno));

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Scoreboard bench for wb_commit_arbiter (NCH=2, DEPTH=4): a queue model of the
// channel FIFOs and round-robin grant predicts every commit, ready and query value.
module tb_wb_commit_arbiter;

  localparam int NCH       = 2;
  localparam int DEPTH     = 4;
  localparam int DBITS     = 32;
  localparam int REGNOBITS = 5;
  localparam int CSRNOBITS = 12;

  typedef struct packed {
    logic        wr_reg;
    logic        wr_csr;
    logic [4:0]  wregno;
    logic [11:0] wcsrno;
    logic [31:0] regval;
  } ent_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NCH-1:0]           ch_valid;
  logic [NCH-1:0]           ch_ready;
  logic [NCH-1:0]           ch_wr_reg;
  logic [NCH*REGNOBITS-1:0] ch_wregno;
  logic [NCH-1:0]           ch_wr_csr;
  logic [NCH*CSRNOBITS-1:0] ch_wcsrno;
  logic [NCH*DBITS-1:0]     ch_regval;
  logic [REGNOBITS-1:0]     query_regno;
  logic                     query_hit;
  logic                     wr_reg_WB;
  logic [REGNOBITS-1:0]     wregno_WB;
  logic                     wr_csr_WB;
  logic [CSRNOBITS-1:0]     wcsrno_WB;
  logic [DBITS-1:0]         regval_WB;
  logic [DBITS-1:0]         retire_count;

  always #5 clk = ~clk;

  wb_commit_arbiter #(
    .NCH(NCH), .DEPTH(DEPTH), .DBITS(DBITS), .REGNOBITS(REGNOBITS), .CSRNOBITS(CSRNOBITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_wr_reg    (ch_wr_reg),
    .ch_wregno    (ch_wregno),
    .ch_wr_csr    (ch_wr_csr),
    .ch_wcsrno    (ch_wcsrno),
    .ch_regval    (ch_regval),
    .query_regno  (query_regno),
    .query_hit    (query_hit),
    .wr_reg_WB    (wr_reg_WB),
    .wregno_WB    (wregno_WB),
    .wr_csr_WB    (wr_csr_WB),
    .wcsrno_WB    (wcsrno_WB),
    .regval_WB    (regval_WB),
    .retire_count (retire_count)
  );

  int errors = 0;
  int checks = 0;

  ent_t src0[$], src1[$];
  ent_t mq0[$], mq1[$];
  ent_t exp_q[$];
  int   m_rr;
  int   m_count;
  logic m_granted;
  logic m_wb_reg;
  logic [4:0] m_wb_regno;

  function automatic ent_t mk(logic wr_reg, logic [4:0] rn, logic wr_csr,
                              logic [11:0] cn, logic [31:0] v);
    ent_t e;
    e.wr_reg = wr_reg;
    e.wregno = rn;
    e.wr_csr = wr_csr;
    e.wcsrno = cn;
    e.regval = v;
    return e;
  endfunction

  function automatic logic m_query(logic [4:0] q);
    logic h;
    h = 1'b0;
    if (q == 5'd0) return 1'b0;
    foreach (mq0[i]) if (mq0[i].wr_reg && mq0[i].wregno == q) h = 1'b1;
    foreach (mq1[i]) if (mq1[i].wr_reg && mq1[i].wregno == q) h = 1'b1;
    if (m_wb_reg && m_wb_regno == q) h = 1'b1;
    return h;
  endfunction

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    exp_q.delete();
    m_rr       = NCH - 1;
    m_count    = 0;
    m_granted  = 1'b0;
    m_wb_reg   = 1'b0;
    m_wb_regno = '0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ch_valid = '0;
    src0.delete();
    src1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Drives the head of each source queue, advances the model by one edge and
  // pushes any predicted commit into exp_q. Returns 1 time unit after the edge.
  task automatic tick();
    ent_t e0, e1, e;
    logic acc0, acc1;
    int   gi;
    e0 = (src0.size() > 0) ? src0[0] : '0;
    e1 = (src1.size() > 0) ? src1[0] : '0;
    e  = '0;
    ch_valid  = {src1.size() > 0, src0.size() > 0};
    ch_wr_reg = {e1.wr_reg, e0.wr_reg};
    ch_wr_csr = {e1.wr_csr, e0.wr_csr};
    ch_wregno = {e1.wregno, e0.wregno};
    ch_wcsrno = {e1.wcsrno, e0.wcsrno};
    ch_regval = {e1.regval, e0.regval};
    acc0 = ch_valid[0] && (mq0.size() < DEPTH);
    acc1 = ch_valid[1] && (mq1.size() < DEPTH);
    gi = -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_rr + k) % NCH;
      if (gi < 0 && (((c == 0) ? mq0.size() : mq1.size()) > 0)) gi = c;
    end
    @(posedge clk);
    m_granted = (gi >= 0);
    if (gi == 0) e = mq0.pop_front();
    else if (gi == 1) e = mq1.pop_front();
    if (m_granted) begin
      exp_q.push_back(e);
      m_rr       = gi;
      m_count    = m_count + 1;
      m_wb_reg   = e.wr_reg && (e.wregno != 5'd0);
      m_wb_regno = e.wregno;
    end else begin
      m_wb_reg = 1'b0;
    end
    if (acc0) begin
      mq0.push_back(e0);
      void'(src0.pop_front());
    end
    if (acc1) begin
      mq1.push_back(e1);
      void'(src1.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    query_regno = 5'd5;
    #1;
    checks++; if (ch_ready !== 2'b11) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 11", ch_ready); end
    checks++; if ({wr_reg_WB, wr_csr_WB} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 00", {wr_reg_WB, wr_csr_WB}); end
    checks++; if ({wregno_WB, wcsrno_WB, regval_WB} !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h/%h/%h expected 0", wregno_WB, wcsrno_WB, regval_WB); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", retire_count); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_query: got %b expected 0", query_hit); end
  endtask

  task automatic test_single();
    ent_t e;
    do_reset();
    query_regno = 5'd5;
    src0.push_back(mk(1'b1, 5'd5, 1'b0, 12'h0, 32'h11));
    tick();
    checks++; if (wr_reg_WB !== 1'b0 || retire_count !== 32'd0) begin errors++; $display("[TB] FAIL single_early: got wr=%b cnt=%0d expected wr=0 cnt=0", wr_reg_WB, retire_count); end
    checks++; if (query_hit !== 1'b1) begin errors++; $display("[TB] FAIL single_query: got %b expected 1", query_hit); end
    tick();
    checks++; if (wr_reg_WB !== 1'b1 || wregno_WB !== 5'd5 || regval_WB !== 32'h11) begin errors++; $display("[TB] FAIL single_commit: got wr=%b rn=%0d val=%h expected wr=1 rn=5 val=11", wr_reg_WB, wregno_WB, regval_WB); end
    checks++; if (retire_count !== 32'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", retire_count); end
    if (m_granted) begin
      e = exp_q.pop_front();
      checks++; if (regval_WB !== e.regval) begin errors++; $display("[TB] FAIL single_sb: got %h expected %h", regval_WB, e.regval); end
    end
  endtask

  task automatic test_round_robin();
    ent_t e;
    logic [31:0] got[$];
    logic [31:0] want [6];
    want = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    do_reset();
    query_regno = 5'd0;
    for (int i = 0; i < 3; i++) begin
      src0.push_back(mk(1'b1, 5'd1, 1'b0, 12'h0, 32'hA0 + i));
      src1.push_back(mk(1'b1, 5'd2, 1'b0, 12'h0, 32'hB0 + i));
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      if (m_granted) begin
        e = exp_q.pop_front();
        got.push_back(regval_WB);
        checks++; if ({wr_reg_WB, wr_csr_WB, wregno_WB, regval_WB} !== {e.wr_reg && (e.wregno != 5'd0), e.wr_csr, e.wregno, e.regval}) begin errors++; $display("[TB] FAIL rr_sb: got rn=%0d val=%h expected rn=%0d val=%h", wregno_WB, regval_WB, e.wregno, e.regval); end
      end else begin
        checks++; if ({wr_reg_WB, wr_csr_WB} !== 2'b00) begin errors++; $display("[TB] FAIL rr_idle: got %b expected 00", {wr_reg_WB, wr_csr_WB}); end
      end
    end
    checks++; if (got.size() != 6) begin errors++; $display("[TB] FAIL rr_ncommits: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %h expected %h", i, got[i], want[i]); end
    end
    checks++; if (retire_count !== 32'd6) begin errors++; $display("[TB] FAIL rr_count: got %0d expected 6", retire_count); end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    do_reset();
    query_regno = 5'd20;
    for (int i = 0; i < 8; i++) begin
      src0.push_back(mk(1'b1, 5'd10, 1'b0, 12'h0, 32'h100 + i));
      src1.push_back(mk(1'b1, 5'd20, 1'b1, 12'h0 + i, 32'h200 + i));
    end
    for (int t = 1; t <= 24; t++) begin
      tick();
      checks++; if (ch_ready !== {mq1.size() < DEPTH, mq0.size() < DEPTH}) begin errors++; $display("[TB] FAIL b2b_ready t=%0d: got %b expected %b", t, ch_ready, {mq1.size() < DEPTH, mq0.size() < DEPTH}); end
      if (t == 6) begin
        checks++; if (ch_ready !== 2'b01) begin errors++; $display("[TB] FAIL b2b_full1: got %b expected 01", ch_ready); end
      end
      if (t == 7) begin
        checks++; if (ch_ready !== 2'b10) begin errors++; $display("[TB] FAIL b2b_full0: got %b expected 10", ch_ready); end
      end
      checks++; if (query_hit !== m_query(query_regno)) begin errors++; $display("[TB] FAIL b2b_query t=%0d: got %b expected %b", t, query_hit, m_query(query_regno)); end
      if (m_granted) begin
        e = exp_q.pop_front();
        checks++; if ({wr_reg_WB, wr_csr_WB, wregno_WB, wcsrno_WB, regval_WB} !== {e.wr_reg && (e.wregno != 5'd0), e.wr_csr, e.wregno, e.wcsrno, e.regval}) begin errors++; $display("[TB] FAIL b2b_sb t=%0d: got val=%h csr=%h expected val=%h csr=%h", t, regval_WB, wcsrno_WB, e.regval, e.wcsrno); end
      end
    end
    checks++; if (retire_count !== 32'd16) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 16", retire_count); end
  endtask

  task automatic test_write_rules();
    do_reset();
    query_regno = 5'd0;
    src0.push_back(mk(1'b1, 5'd0, 1'b0, 12'h000, 32'h55));
    src0.push_back(mk(1'b0, 5'd3, 1'b1, 12'h300, 32'h8));
    src0.push_back(mk(1'b0, 5'd4, 1'b0, 12'h000, 32'h99));
    tick();
    tick();
    checks++; if (wr_reg_WB !== 1'b0 || wr_csr_WB !== 1'b0 || regval_WB !== 32'h55) begin errors++; $display("[TB] FAIL x0_write: got wr=%b csr=%b val=%h expected 0/0/55", wr_reg_WB, wr_csr_WB, regval_WB); end
    checks++; if (retire_count !== 32'd1) begin errors++; $display("[TB] FAIL x0_count: got %0d expected 1", retire_count); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("[TB] FAIL x0_query: got %b expected 0", query_hit); end
    tick();
    checks++; if (wr_csr_WB !== 1'b1 || wcsrno_WB !== 12'h300 || regval_WB !== 32'h8 || wr_reg_WB !== 1'b0) begin errors++; $display("[TB] FAIL csr_write: got csr=%b no=%h val=%h wr=%b expected 1/300/8/0", wr_csr_WB, wcsrno_WB, regval_WB, wr_reg_WB); end
    checks++; if (retire_count !== 32'd2) begin errors++; $display("[TB] FAIL csr_count: got %0d expected 2", retire_count); end
    tick();
    checks++; if ({wr_reg_WB, wr_csr_WB} !== 2'b00 || retire_count !== 32'd3) begin errors++; $display("[TB] FAIL nowrite_retire: got %b cnt=%0d expected 00 cnt=3", {wr_reg_WB, wr_csr_WB}, retire_count); end
    tick();
    checks++; if ({wr_reg_WB, wr_csr_WB} !== 2'b00 || regval_WB !== 32'h99 || retire_count !== 32'd3) begin errors++; $display("[TB] FAIL idle_hold: got %b val=%h cnt=%0d expected 00 val=99 cnt=3", {wr_reg_WB, wr_csr_WB}, regval_WB, retire_count); end
  endtask

  task automatic test_query();
    do_reset();
    query_regno = 5'd7;
    src0.push_back(mk(1'b1, 5'd7, 1'b0, 12'h0, 32'h77));
    #1;
    checks++; if (query_hit !== 1'b0) begin errors++; $display("[TB] FAIL query_before: got %b expected 0", query_hit); end
    tick();
    checks++; if (query_hit !== 1'b1) begin errors++; $display("[TB] FAIL query_buffered: got %b expected 1", query_hit); end
    query_regno = 5'd0;
    #1;
    checks++; if (query_hit !== 1'b0) begin errors++; $display("[TB] FAIL query_x0: got %b expected 0", query_hit); end
    query_regno = 5'd7;
    #1;
    tick();
    checks++; if (query_hit !== 1'b1 || wr_reg_WB !== 1'b1 || wregno_WB !== 5'd7) begin errors++; $display("[TB] FAIL query_commit: got hit=%b wr=%b rn=%0d expected 1/1/7", query_hit, wr_reg_WB, wregno_WB); end
    tick();
    checks++; if (query_hit !== 1'b0 || wr_reg_WB !== 1'b0) begin errors++; $display("[TB] FAIL query_after: got hit=%b wr=%b expected 0/0", query_hit, wr_reg_WB); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    query_regno = 5'd9;
    for (int i = 0; i < 2; i++) begin
      src0.push_back(mk(1'b1, 5'd9, 1'b0, 12'h0, 32'hC0 + i));
      src1.push_back(mk(1'b1, 5'd9, 1'b0, 12'h0, 32'hD0 + i));
    end
    tick();
    tick();
    checks++; if (retire_count !== 32'd1 || query_hit !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre: got cnt=%0d hit=%b expected 1/1", retire_count, query_hit); end
    reset    = 1'b1;
    ch_valid = '0;
    src0.delete();
    src1.delete();
    @(posedge clk);
    #1;
    checks++; if (ch_ready !== 2'b11 || {wr_reg_WB, wr_csr_WB} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_out: got rdy=%b str=%b expected 11/00", ch_ready, {wr_reg_WB, wr_csr_WB}); end
    checks++; if (retire_count !== 32'd0 || query_hit !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got cnt=%0d hit=%b expected 0/0", retire_count, query_hit); end
    reset = 1'b0;
    model_clear();
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++; if (retire_count !== 32'd0 || wr_reg_WB !== 1'b0 || ch_ready !== 2'b11) begin errors++; $display("[TB] FAIL mid_stale t=%0d: got cnt=%0d wr=%b rdy=%b expected 0/0/11", t, retire_count, wr_reg_WB, ch_ready); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    ch_valid    = '0;
    ch_wr_reg   = '0;
    ch_wregno   = '0;
    ch_wr_csr   = '0;
    ch_wcsrno   = '0;
    ch_regval   = '0;
    query_regno = '0;
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_write_rules();
    test_query();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
